immediate_encoder: RTL and testbench

- Inverse of the core's immediate decoder (Immediate_Generator). Takes a 32-bit immediate, an instruction type and a base instruction word, and packs the immediate into the type-specific bit positions.
- Range- and alignment-checks the immediate.
- 2-stage valid/ready pipeline.
- Used by the debug/instruction-injection path and the self-test program builder to synthesize instruction words on-chip.

---
 rtl/immediate_encoder_pkg.sv | 21 ++
 rtl/immediate_encoder_packer.sv | 60 ++++++
 rtl/immediate_encoder.sv | 118 +++++++++++
 tb/tb_immediate_encoder.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/immediate_encoder_pkg.sv
// Shared types for the immediate encoder: instruction-format codes (mirroring the
// core's decoder encoding) and the sign-extension range helper.
package immediate_encoder_pkg;

  typedef enum logic [2:0] {
    TYPE_R = 3'd0,
    TYPE_I = 3'd1,
    TYPE_S = 3'd2,
    TYPE_B = 3'd3,
    TYPE_U = 3'd4,
    TYPE_J = 3'd5
  } instr_type_e;

  // True when imm[31:msb] are all equal, i.e. imm is a sign-extension of imm[msb:0].
  function automatic logic fits_signed(input logic [31:0] imm, input int unsigned msb);
    logic [31:0] upper;
    upper = $signed(imm) >>> msb;
    return (upper == 32'h0000_0000) || (upper == 32'hFFFF_FFFF);
  endfunction

endpackage

// File: rtl/immediate_encoder_packer.sv
// Combinational packing of an immediate into the type-specific bit fields of a base
// instruction word, plus range, alignment and type checks.
module immediate_packer
  import immediate_encoder_pkg::*;
(
  input  logic [2:0]  instruction_type,
  input  logic [31:0] immediate,
  input  logic [31:0] base,
  output logic [31:0] instruction,
  output logic        range_error,
  output logic        align_error,
  output logic        type_error
);

  // Overwrite only the immediate fields of base; erroneous immediates are still truncated in.
  always_comb begin
    instruction = base;
    range_error = 1'b0;
    align_error = 1'b0;
    type_error  = 1'b0;
    case (instruction_type)
      TYPE_R: begin
        instruction = base;
      end
      TYPE_I: begin
        instruction[31:20] = immediate[11:0];
        range_error        = !fits_signed(immediate, 11);
      end
      TYPE_S: begin
        instruction[31:25] = immediate[11:5];
        instruction[11:7]  = immediate[4:0];
        range_error        = !fits_signed(immediate, 11);
      end
      TYPE_B: begin
        instruction[31]    = immediate[12];
        instruction[30:25] = immediate[10:5];
        instruction[11:8]  = immediate[4:1];
        instruction[7]     = immediate[11];
        range_error        = !fits_signed(immediate, 12);
        align_error        = immediate[0];
      end
      TYPE_U: begin
        instruction[31:12] = immediate[31:12];
        range_error        = (immediate[11:0] != 12'h000);
      end
      TYPE_J: begin
        instruction[31]    = immediate[20];
        instruction[30:21] = immediate[10:1];
        instruction[20]    = immediate[11];
        instruction[19:12] = immediate[19:12];
        range_error        = !fits_signed(immediate, 20);
        align_error        = immediate[0];
      end
      default: begin
        type_error = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/immediate_encoder.sv
// Two-stage valid/ready pipeline that turns (type, immediate, base) into an encoded
// instruction word with error flags and a saturating count of erroneous words emitted.
module immediate_encoder
  import immediate_encoder_pkg::*;
#(
  parameter int ERR_CNT_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [2:0]               instruction_type,
  input  logic [31:0]              immediate,
  input  logic [31:0]              base,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              instruction,
  output logic                     range_error,
  output logic                     align_error,
  output logic                     type_error,
  output logic [ERR_CNT_WIDTH-1:0] error_count
);

  logic                     s1_valid_r;
  logic [2:0]               s1_type_r;
  logic [31:0]              s1_imm_r;
  logic [31:0]              s1_base_r;
  logic                     s2_valid_r;
  logic [31:0]              instruction_r;
  logic                     range_error_r;
  logic                     align_error_r;
  logic                     type_error_r;
  logic [ERR_CNT_WIDTH-1:0] error_count_r;

  logic [31:0] packed_word_s;
  logic        packed_range_s;
  logic        packed_align_s;
  logic        packed_type_s;
  logic        s2_load_s;
  logic        accept_s;
  logic        out_fire_s;
  logic        any_error_s;

  // No skid buffer: readiness ripples combinationally back from out_ready, and is held low in reset.
  assign s2_load_s   = s1_valid_r && (!s2_valid_r || out_ready);
  assign in_ready    = reset && !clear && (!s1_valid_r || s2_load_s);
  assign accept_s    = in_valid && in_ready;
  assign out_fire_s  = s2_valid_r && out_ready && !clear;
  assign any_error_s = range_error_r || align_error_r || type_error_r;

  immediate_packer u_packer (
    .instruction_type (s1_type_r),
    .immediate        (s1_imm_r),
    .base             (s1_base_r),
    .instruction      (packed_word_s),
    .range_error      (packed_range_s),
    .align_error      (packed_align_s),
    .type_error       (packed_type_s)
  );

  // Stage 1: capture the raw request.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid_r <= 1'b0;
      s1_type_r  <= 3'd0;
      s1_imm_r   <= 32'h0000_0000;
      s1_base_r  <= 32'h0000_0000;
    end else if (clear) begin
      s1_valid_r <= 1'b0;
    end else if (accept_s) begin
      s1_valid_r <= 1'b1;
      s1_type_r  <= instruction_type;
      s1_imm_r   <= immediate;
      s1_base_r  <= base;
    end else if (s2_load_s) begin
      s1_valid_r <= 1'b0;
    end
  end

  // Stage 2: packed word and flags, held stable while the consumer stalls.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s2_valid_r    <= 1'b0;
      instruction_r <= 32'h0000_0000;
      range_error_r <= 1'b0;
      align_error_r <= 1'b0;
      type_error_r  <= 1'b0;
    end else if (clear) begin
      s2_valid_r <= 1'b0;
    end else if (s2_load_s) begin
      s2_valid_r    <= 1'b1;
      instruction_r <= packed_word_s;
      range_error_r <= packed_range_s;
      align_error_r <= packed_align_s;
      type_error_r  <= packed_type_s;
    end else if (out_ready) begin
      s2_valid_r <= 1'b0;
    end
  end

  // Saturating count of handshaken words carrying any error flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      error_count_r <= '0;
    end else if (out_fire_s && any_error_s && (error_count_r != {ERR_CNT_WIDTH{1'b1}})) begin
      error_count_r <= error_count_r + ERR_CNT_WIDTH'(1);
    end
  end

  assign out_valid   = s2_valid_r;
  assign instruction = instruction_r;
  assign range_error = range_error_r;
  assign align_error = align_error_r;
  assign type_error  = type_error_r;
  assign error_count = error_count_r;

endmodule

// File: tb/tb_immediate_encoder.sv
// Self-checking bench for immediate_encoder: directed cases, backpressure, flush and
// reset, then randomized traffic scored against an arithmetic reference model.
module tb_immediate_encoder;

  logic        clk = 1'b0;
  logic        reset, clear, in_valid, out_ready;
  logic        in_ready, out_valid;
  logic [2:0]  instruction_type;
  logic [31:0] immediate, base, instruction;
  logic        range_error, align_error, type_error;
  logic [7:0]  error_count;

  int n_checks = 0;
  int n_errors = 0;
  int ec_model = 0;

  typedef struct {
    logic [2:0]  t;
    logic [31:0] imm;
    logic [31:0] b;
  } word_t;
  word_t sb[$];

  immediate_encoder #(.ERR_CNT_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready),
    .instruction_type(instruction_type), .immediate(immediate), .base(base),
    .out_valid(out_valid), .out_ready(out_ready), .instruction(instruction),
    .range_error(range_error), .align_error(align_error), .type_error(type_error),
    .error_count(error_count)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_word(input logic [2:0] t, input logic [31:0] imm, input logic [31:0] b);
    case (t)
      3'd1:    return {imm[11:0], b[19:0]};
      3'd2:    return {imm[11:5], b[24:12], imm[4:0], b[6:0]};
      3'd3:    return {imm[12], imm[10:5], b[24:12], imm[4:1], imm[11], b[6:0]};
      3'd4:    return {imm[31:12], b[11:0]};
      3'd5:    return {imm[20], imm[10:1], imm[11], imm[19:12], b[11:0]};
      default: return b;
    endcase
  endfunction

  // {range, align, type} from the numeric ranges of each format
  function automatic logic [2:0] model_flags(input logic [2:0] t, input logic [31:0] imm);
    int s;
    logic rng, aln, typ;
    s = $signed(imm);
    case (t)
      3'd1, 3'd2: rng = (s < -2048) || (s > 2047);
      3'd3:       rng = (s < -4096) || (s > 4095);
      3'd4:       rng = (imm % 32'd4096) != 32'd0;
      3'd5:       rng = (s < -1048576) || (s > 1048575);
      default:    rng = 1'b0;
    endcase
    aln = ((t == 3'd3) || (t == 3'd5)) && ((imm % 32'd2) == 32'd1);
    typ = (t > 3'd5);
    return {rng, aln, typ};
  endfunction

  function automatic logic [31:0] decode(input logic [2:0] t, input logic [31:0] i);
    case (t)
      3'd1:    return {{20{i[31]}}, i[31:20]};
      3'd2:    return {{20{i[31]}}, i[31:25], i[11:7]};
      3'd3:    return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      3'd4:    return {i[31:12], 12'h000};
      3'd5:    return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      default: return 32'h0000_0000;
    endcase
  endfunction

  function automatic logic [31:0] field_mask(input logic [2:0] t);
    case (t)
      3'd1:       return 32'hFFF0_0000;
      3'd2, 3'd3: return 32'hFE00_0F80;
      3'd4, 3'd5: return 32'hFFFF_F000;
      default:    return 32'h0000_0000;
    endcase
  endfunction

  function automatic logic [31:0] gen_legal(input logic [2:0] t);
    int v;
    logic [31:0] r;
    case (t)
      3'd1, 3'd2: v = int'($urandom_range(4095, 0)) - 2048;
      3'd3:       v = int'($urandom_range(4095, 0)) * 2 - 4096;
      3'd4: begin
        r = $urandom();
        v = int'(r & 32'hFFFF_F000);
      end
      3'd5:       v = int'($urandom_range(1048575, 0)) * 2 - 1048576;
      default:    v = 0;
    endcase
    return 32'(v);
  endfunction

  task automatic send_dir(input string tag, input logic [2:0] t, input logic [31:0] imm,
                          input logic [31:0] b, input logic [31:0] exp_i, input logic [2:0] exp_f,
                          input int exp_ec);
    int lat;
    @(negedge clk);
    in_valid = 1'b1; instruction_type = t; immediate = imm; base = b; out_ready = 1'b1;
    #1;
    check_eq({tag, ".in_ready"}, in_ready, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 8) begin
      @(negedge clk);
      lat++;
    end
    check_eq({tag, ".latency"}, 32'(lat), 32'd2);
    check_eq({tag, ".instr"}, instruction, exp_i);
    check_eq({tag, ".flags"}, {range_error, align_error, type_error}, exp_f);
    @(negedge clk);
    check_eq({tag, ".one_cycle"}, out_valid, 1'b0);
    check_eq({tag, ".err_cnt"}, error_count, 32'(exp_ec));
  endtask

  task automatic run_random(input int n, input bit legal);
    int sent = 0;
    int cycles = 0;
    word_t w, e;
    logic [2:0] f;
    sb.delete();
    while ((sent < n || sb.size() > 0) && cycles < n * 10 + 200) begin
      @(negedge clk);
      cycles++;
      out_ready = ($urandom_range(3, 0) != 0);
      in_valid  = (sent < n) && ($urandom_range(3, 0) != 0);
      if (legal) begin
        w.t   = 3'(1 + $urandom_range(4, 0));
        w.imm = gen_legal(w.t);
      end else begin
        w.t   = 3'($urandom_range(7, 0));
        w.imm = ($urandom_range(1, 0) == 1) ? $urandom() : ($urandom() & 32'h0000_1FFF);
      end
      w.b = $urandom();
      instruction_type = w.t; immediate = w.imm; base = w.b;
      #1;
      if (out_valid && out_ready) begin
        check_eq("rnd.err_cnt", error_count, 32'(ec_model));
        if (sb.size() == 0) begin
          check_eq("rnd.unexpected_out", out_valid, 1'b0);
        end else begin
          e = sb.pop_front();
          f = model_flags(e.t, e.imm);
          check_eq("rnd.instr", instruction, model_word(e.t, e.imm, e.b));
          check_eq("rnd.flags", {range_error, align_error, type_error}, f);
          if (f == 3'b000 && e.t >= 3'd1 && e.t <= 3'd5) begin
            check_eq("rnd.roundtrip", decode(e.t, instruction), e.imm);
            check_eq("rnd.base_kept", (instruction ^ e.b) & ~field_mask(e.t), 32'h0000_0000);
          end
          if (f != 3'b000 && ec_model < 255) ec_model++;
        end
      end
      if (in_valid && in_ready) begin
        sb.push_back(w);
        sent++;
      end
    end
    in_valid = 1'b0;
    check_eq("rnd.all_sent", 32'(sent), 32'(n));
    check_eq("rnd.drained", 32'(sb.size()), 32'd0);
    @(negedge clk);
    check_eq("rnd.final_err_cnt", error_count, 32'(ec_model));
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int acc, got, first;
    logic [31:0] bp_imm[4];
    reset = 1'b1; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    instruction_type = 3'd0; immediate = 32'h0; base = 32'h0;
    #2 reset = 1'b0;
    #1;
    check_eq("rst.out_valid", out_valid, 1'b0);
    check_eq("rst.instr", instruction, 32'h0000_0000);
    check_eq("rst.flags", {range_error, align_error, type_error}, 3'b000);
    check_eq("rst.err_cnt", error_count, 32'd0);
    in_valid = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("rst.in_ready", in_ready, 1'b0);
    in_valid = 1'b0;
    reset = 1'b1;

    send_dir("i_type", 3'd1, 32'hFFFF_FFFF, 32'h0000_0013, 32'hFFF0_0013, 3'b000, 0);
    send_dir("b_ok",   3'd3, 32'hFFFF_F000, 32'h0000_0063, 32'h8000_0063, 3'b000, 0);
    send_dir("b_rng",  3'd3, 32'h0000_1000, 32'h0000_0063, 32'h8000_0063, 3'b100, 1);
    send_dir("u_type", 3'd4, 32'h1234_5000, 32'h0000_0037, 32'h1234_5037, 3'b000, 1);
    send_dir("j_algn", 3'd5, 32'h0000_0003, 32'h0000_006F, 32'h0020_006F, 3'b010, 2);
    send_dir("type7",  3'd7, 32'h0000_0FFF, 32'h1234_5678, 32'h1234_5678, 3'b001, 3);
    ec_model = 3;

    // backpressure: two words fill the pipe, then the stall holds S2 steady
    for (int k = 0; k < 4; k++) bp_imm[k] = 32'((k + 1) * 4096 + k * 32'h0010_0000);
    acc = 0;
    out_ready = 1'b0;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      in_valid = (acc < 4);
      instruction_type = 3'd4; immediate = bp_imm[acc % 4]; base = 32'h0000_0037;
      #1;
      if (c >= 2) begin
        check_eq("bp.in_ready_low", in_ready, 1'b0);
        check_eq("bp.hold_valid", out_valid, 1'b1);
        check_eq("bp.hold_instr", instruction, model_word(3'd4, bp_imm[0], 32'h0000_0037));
      end
      if (in_valid && in_ready) acc++;
    end
    check_eq("bp.accepted", 32'(acc), 32'd2);
    got = 0; first = 0;
    for (int c = 0; c < 12 && got < 4; c++) begin
      @(negedge clk);
      out_ready = 1'b1;
      in_valid = (acc < 4);
      instruction_type = 3'd4; immediate = bp_imm[acc % 4]; base = 32'h0000_0037;
      #1;
      if (out_valid && out_ready) begin
        if (got == 0) first = c;
        check_eq("bp.order", instruction, model_word(3'd4, bp_imm[got], 32'h0000_0037));
        check_eq("bp.rate", 32'(c - first), 32'(got));
        got++;
      end
      if (in_valid && in_ready) acc++;
    end
    in_valid = 1'b0;
    check_eq("bp.all_out", 32'(got), 32'd4);

    // flush with both stages full of erroneous words and a new offer pending
    @(negedge clk);
    acc = 0;
    out_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      in_valid = 1'b1; instruction_type = 3'd7; immediate = $urandom(); base = 32'hCAFE_0000 + 32'(k);
      #1;
      if (in_valid && in_ready) acc++;
    end
    check_eq("clr.filled", 32'(acc), 32'd2);
    @(negedge clk);
    clear = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    check_eq("clr.in_ready", in_ready, 1'b0);
    @(negedge clk);
    clear = 1'b0; in_valid = 1'b0;
    check_eq("clr.out_valid", out_valid, 1'b0);
    check_eq("clr.err_cnt", error_count, 32'(ec_model));
    @(negedge clk);
    check_eq("clr.s1_flushed", out_valid, 1'b0);

    // async reset in the middle of a stream
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      in_valid = 1'b1; instruction_type = 3'd1; immediate = 32'(k + 1); base = 32'h0000_0013;
    end
    @(posedge clk);
    #3 reset = 1'b0;
    #1;
    check_eq("arst.out_valid", out_valid, 1'b0);
    check_eq("arst.instr", instruction, 32'h0000_0000);
    check_eq("arst.flags", {range_error, align_error, type_error}, 3'b000);
    check_eq("arst.err_cnt", error_count, 32'd0);
    check_eq("arst.in_ready", in_ready, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    ec_model = 0;

    run_random(10000, 1'b1);
    run_random(700, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
